io_port_ctrl: RTL and testbench

Buffered I/O peripheral on the far side of the processor's `In_Port`/`Out_Port`/`int` pins. It accepts words written by OUT instructions into an output FIFO and drains them to an external consumer over valid/ready. It accepts words from an external producer into an input FIFO that drives `In_Port` for IN instructions. It raises the processor's edge-triggered `int` pin when new input data arrives, with a hold-off window so one burst produces one interrupt.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_fifo.sv | 70 +++++++
 rtl/io_port_ctrl.sv | 124 ++++++++++++
 tb/tb_io_port_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the buffered I/O port controller.
package io_pkg;

   localparam int IO_WIDTH       = 16;
   localparam int IO_DEPTH       = 4;
   localparam int IO_INT_HOLDOFF = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      HOLD  = 2'd2
   } int_state_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with zero-latency head read and an explicit occupancy count.
// A push while full is accepted when a pop happens in the same cycle.
module io_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   // Head is masked to zero while empty so stale storage never leaks out.
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   // Accept/advance decisions; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   // Control state: pointers and occupancy, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are unreachable after reset because count is 0.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/io_port_ctrl.sv
// Buffered I/O peripheral: output FIFO fed by OUT, input FIFO drained by IN,
// and an edge interrupt with a hold-off window that coalesces bursts.
module io_port_ctrl
   import io_pkg::*;
#(
   parameter int DEPTH       = IO_DEPTH,
   parameter int INT_HOLDOFF = IO_INT_HOLDOFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     out_wr,
   input  logic [IO_WIDTH-1:0]      out_port_data,
   output logic [IO_WIDTH-1:0]      ext_out_data,
   output logic                     ext_out_valid,
   input  logic                     ext_out_ready,
   input  logic [IO_WIDTH-1:0]      ext_in_data,
   input  logic                     ext_in_valid,
   output logic                     ext_in_ready,
   input  logic                     in_rd,
   output logic [IO_WIDTH-1:0]      in_port,
   input  logic                     int_en,
   output logic                     int_req,
   output logic [$clog2(DEPTH):0]   in_count,
   output logic                     out_ovf
);

   localparam int HW = $clog2(INT_HOLDOFF + 1);

   logic             out_full, out_empty;
   logic             in_full, in_empty;
   logic [$clog2(DEPTH):0] out_count;
   logic             in_push_acc;
   logic             out_drop;
   logic             unused_fifo;

   int_state_e       state_q, state_d;
   logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
   logic             pending_q, pending_d;
   logic             int_req_q, int_req_d;
   logic             out_ovf_q, out_ovf_d;
   logic             enter_pulse;

   assign ext_in_ready  = ~in_full;
   assign ext_out_valid = ~out_empty;
   assign in_push_acc   = ext_in_valid & ~in_full;
   // A full output FIFO still takes the word when the consumer pops this cycle.
   assign out_drop      = out_wr & out_full & ~ext_out_ready;
   assign int_req       = int_req_q;
   assign out_ovf       = out_ovf_q;
   assign unused_fifo   = ^{out_count, in_empty};

   io_fifo #(.WIDTH(IO_WIDTH), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (out_wr),
      .pop   (ext_out_ready),
      .wdata (out_port_data),
      .rdata (ext_out_data),
      .full  (out_full),
      .empty (out_empty),
      .count (out_count)
   );

   io_fifo #(.WIDTH(IO_WIDTH), .DEPTH(DEPTH)) u_in_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_push_acc),
      .pop   (in_rd),
      .wdata (ext_in_data),
      .rdata (in_port),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   // Interrupt FSM next state, pending bookkeeping and sticky overflow.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      enter_pulse = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q & int_en) begin
               state_d     = PULSE;
               enter_pulse = 1'b1;
            end
         end
         PULSE: begin
            state_d    = HOLD;
            hold_cnt_d = HW'(INT_HOLDOFF - 1);
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A push on the same edge as pulse entry stays pending for the next pulse.
      pending_d = (pending_q & ~enter_pulse) | in_push_acc;
      int_req_d = (state_d == PULSE);
      out_ovf_d = out_ovf_q | out_drop;
   end

   // Interrupt and overflow state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         hold_cnt_q <= '0;
         pending_q  <= 1'b0;
         int_req_q  <= 1'b0;
         out_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         pending_q  <= pending_d;
         int_req_q  <= int_req_d;
         out_ovf_q  <= out_ovf_d;
      end
   end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl: a per-cycle vector table for the FIFO paths
// plus hand-written sequences for interrupt timing, full-FIFO corner and reset.
module tb_io_port_ctrl;

   logic        clk;
   logic        reset;
   logic        out_wr;
   logic [15:0] out_port_data;
   logic [15:0] ext_out_data;
   logic        ext_out_valid;
   logic        ext_out_ready;
   logic [15:0] ext_in_data;
   logic        ext_in_valid;
   logic        ext_in_ready;
   logic        in_rd;
   logic [15:0] in_port;
   logic        int_en;
   logic        int_req;
   logic [2:0]  in_count;
   logic        out_ovf;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pulses[$];

   io_port_ctrl #(.DEPTH(4), .INT_HOLDOFF(6)) dut (
      .clk           (clk),
      .reset         (reset),
      .out_wr        (out_wr),
      .out_port_data (out_port_data),
      .ext_out_data  (ext_out_data),
      .ext_out_valid (ext_out_valid),
      .ext_out_ready (ext_out_ready),
      .ext_in_data   (ext_in_data),
      .ext_in_valid  (ext_in_valid),
      .ext_in_ready  (ext_in_ready),
      .in_rd         (in_rd),
      .in_port       (in_port),
      .int_en        (int_en),
      .int_req       (int_req),
      .in_count      (in_count),
      .out_ovf       (out_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        ow;
      logic [15:0] od;
      logic        ordy;
      logic [15:0] id;
      logic        iv;
      logic        rd;
      logic [15:0] e_inport;
      logic [2:0]  e_cnt;
      logic        e_irdy;
      logic        e_oval;
      logic [15:0] e_odata;
      logic        e_ovf;
   } vec_t;

   localparam int NV = 27;
   vec_t tv[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then sample after the next rising edge.
   task automatic step(input logic ow, input logic [15:0] od, input logic ordy,
                       input logic [15:0] id, input logic iv, input logic rd, input logic en);
      out_wr        = ow;
      out_port_data = od;
      ext_out_ready = ordy;
      ext_in_data   = id;
      ext_in_valid  = iv;
      in_rd         = rd;
      int_en        = en;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (int_req === 1'b1) pulses.push_back(cyc);
   endtask

   task automatic do_reset();
      out_wr        = 1'b0;
      out_port_data = 16'h0;
      ext_out_ready = 1'b0;
      ext_in_data   = 16'h0;
      ext_in_valid  = 1'b0;
      in_rd         = 1'b0;
      int_en        = 1'b0;
      reset         = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      pulses.delete();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " in_port"},       32'(in_port),       32'h0);
      chk({tag, " in_count"},      32'(in_count),      32'h0);
      chk({tag, " ext_in_ready"},  32'(ext_in_ready),  32'h1);
      chk({tag, " ext_out_valid"}, 32'(ext_out_valid), 32'h0);
      chk({tag, " ext_out_data"},  32'(ext_out_data),  32'h0);
      chk({tag, " int_req"},       32'(int_req),       32'h0);
      chk({tag, " out_ovf"},       32'(out_ovf),       32'h0);
   endtask

   initial begin
      //        ow    od       ordy  id       iv    rd     inport   cnt   irdy  oval  odata    ovf
      tv[0]  = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[1]  = '{1'b0, 16'h0,    1'b0, 16'hA5A5, 1'b1, 1'b0, 16'hA5A5, 3'd1, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[2]  = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    3'd0, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[3]  = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    3'd0, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[4]  = '{1'b0, 16'h0,    1'b0, 16'h1111, 1'b1, 1'b0, 16'h1111, 3'd1, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[5]  = '{1'b0, 16'h0,    1'b0, 16'h2222, 1'b1, 1'b0, 16'h1111, 3'd2, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[6]  = '{1'b0, 16'h0,    1'b0, 16'h3333, 1'b1, 1'b0, 16'h1111, 3'd3, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[7]  = '{1'b0, 16'h0,    1'b0, 16'h4444, 1'b1, 1'b0, 16'h1111, 3'd4, 1'b0, 1'b0, 16'h0,    1'b0};
      tv[8]  = '{1'b0, 16'h0,    1'b0, 16'h5555, 1'b1, 1'b0, 16'h1111, 3'd4, 1'b0, 1'b0, 16'h0,    1'b0};
      tv[9]  = '{1'b0, 16'h0,    1'b0, 16'h5555, 1'b1, 1'b1, 16'h2222, 3'd3, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[10] = '{1'b0, 16'h0,    1'b0, 16'h5555, 1'b1, 1'b0, 16'h2222, 3'd4, 1'b0, 1'b0, 16'h0,    1'b0};
      tv[11] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h3333, 3'd3, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[12] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h4444, 3'd2, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[13] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h5555, 3'd1, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[14] = '{1'b0, 16'h0,    1'b0, 16'h6666, 1'b1, 1'b1, 16'h6666, 3'd1, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[15] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    3'd0, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[16] = '{1'b0, 16'h0,    1'b0, 16'h7777, 1'b1, 1'b1, 16'h7777, 3'd1, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[17] = '{1'b0, 16'h0,    1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    3'd0, 1'b1, 1'b0, 16'h0,    1'b0};
      tv[18] = '{1'b1, 16'h0001, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0001, 1'b0};
      tv[19] = '{1'b1, 16'h0002, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0001, 1'b0};
      tv[20] = '{1'b1, 16'h0003, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0001, 1'b0};
      tv[21] = '{1'b1, 16'h0004, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0001, 1'b0};
      tv[22] = '{1'b1, 16'h0005, 1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0001, 1'b1};
      tv[23] = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0002, 1'b1};
      tv[24] = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0003, 1'b1};
      tv[25] = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b1, 16'h0004, 1'b1};
      tv[26] = '{1'b0, 16'h0,    1'b1, 16'h0,    1'b0, 1'b0, 16'h0,    3'd0, 1'b1, 1'b0, 16'h0,    1'b1};

      // Table: FIFO paths with interrupts disabled.
      do_reset();
      for (int i = 0; i < NV; i++) begin
         step(tv[i].ow, tv[i].od, tv[i].ordy, tv[i].id, tv[i].iv, tv[i].rd, 1'b0);
         chk($sformatf("v%0d in_port", i),       32'(in_port),       32'(tv[i].e_inport));
         chk($sformatf("v%0d in_count", i),      32'(in_count),      32'(tv[i].e_cnt));
         chk($sformatf("v%0d ext_in_ready", i),  32'(ext_in_ready),  32'(tv[i].e_irdy));
         chk($sformatf("v%0d ext_out_valid", i), 32'(ext_out_valid), 32'(tv[i].e_oval));
         chk($sformatf("v%0d ext_out_data", i),  32'(ext_out_data),  32'(tv[i].e_odata));
         chk($sformatf("v%0d out_ovf", i),       32'(out_ovf),       32'(tv[i].e_ovf));
         chk($sformatf("v%0d int_req", i),       32'(int_req),       32'h0);
      end

      // Single push: one pulse two edges after the push.
      do_reset();
      step(1'b0, 16'h0, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b1);
      chk("A in_port", 32'(in_port), 32'hA5A5);
      chk("A in_count", 32'(in_count), 32'd1);
      chk("A int_req early", 32'(int_req), 32'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("A int_req pulse", 32'(int_req), 32'h1);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
      chk("A int_req one cycle", 32'(int_req), 32'h0);
      chk("A in_port after rd", 32'(in_port), 32'h0);
      chk("A in_count after rd", 32'(in_count), 32'd0);
      repeat (10) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("A pulse count", 32'(pulses.size()), 32'd1);

      // Burst coalescing and minimum pulse spacing.
      do_reset();
      step(1'b0, 16'h0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1);
      repeat (2) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("B one pulse in burst", 32'(pulses.size()), 32'd1);
      step(1'b0, 16'h0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b1);
      repeat (18) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("B pulse count", 32'(pulses.size()), 32'd2);
      chk("B in_count", 32'(in_count), 32'd4);
      if (pulses.size() == 2) begin
         chk("B first pulse cycle", 32'(pulses[0]), 32'd2);
         chk("B pulse spacing", 32'(pulses[1] - pulses[0]), 32'd8);
      end

      // Interrupt disabled: pending is remembered until int_en rises.
      do_reset();
      step(1'b0, 16'h0, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      repeat (4) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("C no pulse while disabled", 32'(pulses.size()), 32'd0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("C pulse on enable", 32'(int_req), 32'h1);

      // Output FIFO full with simultaneous write and pop.
      do_reset();
      step(1'b1, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0002, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0004, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'h0009, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("D ovf after full wr+pop", 32'(out_ovf), 32'h0);
      chk("D head after full wr+pop", 32'(ext_out_data), 32'h0002);
      step(1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("D drain 2", 32'(ext_out_data), 32'h0003);
      step(1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("D drain 3", 32'(ext_out_data), 32'h0004);
      step(1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("D drain 4", 32'(ext_out_data), 32'h0009);
      chk("D valid before last", 32'(ext_out_valid), 32'h1);
      step(1'b0, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
      chk("D valid after last", 32'(ext_out_valid), 32'h0);
      chk("D ovf final", 32'(out_ovf), 32'h0);

      // Asynchronous reset while the interrupt FSM is holding off.
      do_reset();
      step(1'b1, 16'h0011, 1'b0, 16'h0021, 1'b1, 1'b0, 1'b1);
      step(1'b1, 16'h0012, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0013, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1);
      step(1'b1, 16'h0014, 1'b0, 16'h0022, 1'b1, 1'b0, 1'b1);
      step(1'b1, 16'h0015, 1'b0, 16'h0,    1'b0, 1'b0, 1'b1);
      chk("E ovf before reset", 32'(out_ovf), 32'h1);
      chk("E in_count before reset", 32'(in_count), 32'd2);
      chk("E first pulse", 32'(pulses.size()), 32'd1);
      out_wr = 1'b0;
      #2 reset = 1'b1;
      #1 chk_idle_outputs("E async");
      pulses.delete();
      @(negedge clk);
      reset = 1'b0;
      chk_idle_outputs("E after reset");
      repeat (15) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("E no pulse after reset", 32'(pulses.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
